spi_wb_mbox: RTL

- Wishbone slave placed directly downstream of the SPI-to-Wishbone bridge, on one of its WB_N cycle/ack lanes.
- Provides two word FIFOs between the SPI host and fabric logic:
  - H2F: host writes words over SPI/WB; fabric drains them via a valid/ready stream.
  - F2H: fabric pushes words via a valid/ready stream; host reads them over SPI/WB.
- Status, control and sticky error flags are exposed as CSRs, so the host can poll levels before bursting.

---
 rtl/spi_wb_mbox_pkg.sv | 21 ++
 rtl/mbox_fifo_sync.sv | 59 +++++
 rtl/spi_wb_mbox.sv | 121 ++++++++++++
 3 files changed

// File: rtl/spi_wb_mbox_pkg.sv
// Register map and bit positions shared by the mailbox top and its bench.
package spi_wb_mbox_pkg;

  localparam logic [3:0] ADDR_STATUS = 4'h0;
  localparam logic [3:0] ADDR_CTRL   = 4'h1;
  localparam logic [3:0] ADDR_H2F    = 4'h2;
  localparam logic [3:0] ADDR_F2H    = 4'h3;

  localparam int ST_H2F_LVL_LSB = 0;
  localparam int ST_F2H_LVL_LSB = 8;
  localparam int ST_H2F_OVF     = 16;
  localparam int ST_F2H_UNF     = 17;
  localparam int ST_H2F_FULL    = 18;
  localparam int ST_F2H_EMPTY   = 19;

  localparam int CTRL_FLUSH_H2F = 0;
  localparam int CTRL_FLUSH_F2H = 1;
  localparam int CTRL_CLR_OVF   = 2;
  localparam int CTRL_CLR_UNF   = 3;

endpackage

// File: rtl/mbox_fifo_sync.sv
// Single-clock word FIFO: push/pop/flush, head word combinational from the read pointer.
// Full/empty come from pre-cycle level, so a push into a full FIFO is rejected even alongside a pop.
module mbox_fifo_sync #(
  parameter int W          = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [W-1:0]          i_wdata,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic [W-1:0]          o_head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [W-1:0]          r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  // Flush overrides both sides; a push lost to a flush is not an overflow.
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spi_wb_mbox.sv
// Wishbone mailbox: host<->fabric word FIFOs with STATUS/CTRL CSRs; ack one cycle after cyc.
// Fabric side is valid/ready; host pushes to a full H2F or pops an empty F2H set sticky flags.
module spi_wb_mbox
  import spi_wb_mbox_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack,
  output logic [31:0] h2f_data,
  output logic        h2f_valid,
  input  logic        h2f_ready,
  input  logic [31:0] f2h_data,
  input  logic        f2h_valid,
  output logic        f2h_ready
);

  logic        r_ack;
  logic [31:0] r_rdata;
  logic        r_h2f_ovf;
  logic        r_f2h_unf;

  logic        w_access, w_wr, w_rd, w_ctrl_wr;
  logic        w_h2f_push, w_h2f_pop, w_h2f_flush, w_h2f_full, w_h2f_empty;
  logic        w_f2h_pop, w_f2h_flush, w_f2h_full, w_f2h_empty;
  logic [DEPTH_LOG2:0] w_h2f_level, w_f2h_level;
  logic [31:0] w_f2h_head;
  logic [31:0] w_status;
  logic [31:0] w_rd_dat;

  // Side effects fire on the cycle before ack; the ack cycle itself is never an access.
  assign w_access    = wb_cyc & ~r_ack;
  assign w_wr        = w_access & wb_we;
  assign w_rd        = w_access & ~wb_we;
  assign w_ctrl_wr   = w_wr && (wb_addr == ADDR_CTRL);

  assign w_h2f_push  = w_wr && (wb_addr == ADDR_H2F);
  assign w_h2f_pop   = h2f_ready & ~w_h2f_empty;
  assign w_h2f_flush = w_ctrl_wr & wb_wdata[CTRL_FLUSH_H2F];
  assign w_f2h_pop   = w_rd && (wb_addr == ADDR_F2H);
  assign w_f2h_flush = w_ctrl_wr & wb_wdata[CTRL_FLUSH_F2H];

  mbox_fifo_sync #(.W(32), .DEPTH_LOG2(DEPTH_LOG2)) u_h2f (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (w_h2f_push),
    .i_wdata (wb_wdata),
    .i_pop   (w_h2f_pop),
    .i_flush (w_h2f_flush),
    .o_full  (w_h2f_full),
    .o_empty (w_h2f_empty),
    .o_level (w_h2f_level),
    .o_head  (h2f_data)
  );

  mbox_fifo_sync #(.W(32), .DEPTH_LOG2(DEPTH_LOG2)) u_f2h (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_push  (f2h_valid),
    .i_wdata (f2h_data),
    .i_pop   (w_f2h_pop),
    .i_flush (w_f2h_flush),
    .o_full  (w_f2h_full),
    .o_empty (w_f2h_empty),
    .o_level (w_f2h_level),
    .o_head  (w_f2h_head)
  );

  assign h2f_valid = ~w_h2f_empty;
  assign f2h_ready = ~w_f2h_full;
  assign wb_ack    = r_ack;
  assign wb_rdata  = r_rdata;

  always_comb begin
    w_status = '0;
    w_status[ST_H2F_LVL_LSB +: 8] = 8'(w_h2f_level);
    w_status[ST_F2H_LVL_LSB +: 8] = 8'(w_f2h_level);
    w_status[ST_H2F_OVF]   = r_h2f_ovf;
    w_status[ST_F2H_UNF]   = r_f2h_unf;
    w_status[ST_H2F_FULL]  = w_h2f_full;
    w_status[ST_F2H_EMPTY] = w_f2h_empty;
  end

  always_comb begin
    w_rd_dat = '0;
    if (w_rd) begin
      case (wb_addr)
        ADDR_STATUS: w_rd_dat = w_status;
        ADDR_F2H:    w_rd_dat = w_f2h_empty ? 32'h0 : w_f2h_head;
        default:     w_rd_dat = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_rdata   <= '0;
      r_h2f_ovf <= 1'b0;
      r_f2h_unf <= 1'b0;
    end else begin
      r_ack   <= w_access;
      r_rdata <= w_rd_dat;
      if (w_h2f_push && w_h2f_full)
        r_h2f_ovf <= 1'b1;
      else if (w_ctrl_wr && wb_wdata[CTRL_CLR_OVF])
        r_h2f_ovf <= 1'b0;
      if (w_f2h_pop && w_f2h_empty)
        r_f2h_unf <= 1'b1;
      else if (w_ctrl_wr && wb_wdata[CTRL_CLR_UNF])
        r_f2h_unf <= 1'b0;
    end
  end

endmodule
